// File: rtl/ifid_fetch_unit.sv
// ifid_fetch_unit
//   Fetch stage that answers the hazard detector. It owns the PC and the
//   IF/ID pipeline register, and it applies the PcWrite/IFIDWrite stall
//   requests and the branch redirects from EX. It also talks to an
//   instruction memory that can insert wait states.
//
//   Handshake: o_imem_req/i_imem_ready. A fetch completes on a cycle with
//   o_imem_req=1 and i_imem_ready=1. o_imem_addr is always the current PC.
//   While o_imem_req is low, i_imem_ready and i_imem_rdata are ignored.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_PcWrite, i_IFIDWrite  hazard stall requests (0 = hold)
//   i_branch_taken/target   redirect from EX; also flushes IF/ID
//   o_imem_req/addr         fetch request and address
//   i_imem_ready/rdata      fetch data and its valid strobe
//   o_ifid_instr/pc4/valid  IF/ID pipeline register
//   o_fetch_wait            memory wait in progress (state == WAIT)
//   o_misalign_err          sticky flag: a branch target had bits [1:0] != 0
//   o_bubble_cnt            saturating count of wait-state bubbles
//   o_dbg_state             FSM state (0=FETCH, 1=WAIT, 2=HOLD)
module ifid_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_PcWrite,
  input  logic             i_IFIDWrite,
  input  logic             i_branch_taken,
  input  logic [31:0]      i_branch_target,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_ready,
  input  logic [31:0]      i_imem_rdata,
  output logic [31:0]      o_ifid_instr,
  output logic [31:0]      o_ifid_pc4,
  output logic             o_ifid_valid,
  output logic             o_fetch_wait,
  output logic             o_misalign_err,
  output logic [CNT_W-1:0] o_bubble_cnt,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_ifid_instr;
  logic [31:0]        r_ifid_pc4;
  logic               r_ifid_valid;
  logic [31:0]        r_hb_instr;
  logic [31:0]        r_hb_pc4;
  logic               r_misalign;
  logic [CNT_W-1:0]   r_bubble_cnt;

  logic [31:0]        w_pc4;
  logic               w_fetch_done;

  // Wraps modulo 2^32 by construction.
  assign w_pc4        = r_pc + 32'd4;
  // HOLD issues no request, so a ready strobe there is not a completion.
  assign w_fetch_done = (r_state != S_HOLD) && i_imem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
      r_hb_instr   <= NOP_INSTR;
      r_hb_pc4     <= 32'd0;
      r_misalign   <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (i_branch_taken) begin
      // The redirect wins over stalls and discards any fetch completing now.
      r_state      <= S_FETCH;
      r_pc         <= {i_branch_target[31:2], 2'b00};
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
      r_hb_instr   <= NOP_INSTR;
      r_hb_pc4     <= 32'd0;
      if (i_branch_target[1:0] != 2'b00) r_misalign <= 1'b1;
    end else if (r_state == S_HOLD) begin
      // The PC already moved past the buffered word, so PcWrite is ignored here.
      if (i_IFIDWrite) begin
        r_ifid_instr <= r_hb_instr;
        r_ifid_pc4   <= r_hb_pc4;
        r_ifid_valid <= 1'b1;
        r_state      <= S_FETCH;
      end
    end else if (w_fetch_done) begin
      if (i_PcWrite) r_pc <= w_pc4;
      if (i_IFIDWrite) begin
        r_ifid_instr <= i_imem_rdata;
        r_ifid_pc4   <= w_pc4;
        r_ifid_valid <= 1'b1;
        r_state      <= S_FETCH;
      end else if (i_PcWrite) begin
        // IF/ID is frozen but the PC advances: park the word until it is released.
        r_hb_instr   <= i_imem_rdata;
        r_hb_pc4     <= w_pc4;
        r_state      <= S_HOLD;
      end else begin
        // Load-use stall: drop the data; the same PC is refetched.
        r_state      <= S_FETCH;
      end
    end else begin
      r_state <= S_WAIT;
      if (i_IFIDWrite) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
        if (r_bubble_cnt != {CNT_W{1'b1}}) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign o_imem_req     = !i_rst && (r_state != S_HOLD);
  assign o_imem_addr    = r_pc;
  assign o_ifid_instr   = r_ifid_instr;
  assign o_ifid_pc4     = r_ifid_pc4;
  assign o_ifid_valid   = r_ifid_valid;
  assign o_fetch_wait   = (r_state == S_WAIT);
  assign o_misalign_err = r_misalign;
  assign o_bubble_cnt   = r_bubble_cnt;
  assign o_dbg_state    = r_state;

endmodule
